sad_accumulator: RTL

Sum-of-absolute-differences accumulator. It sits directly downstream of the 8-bit absolute-difference stage and consumes one `diff` sample per accepted beat. Over a block of `N` samples it produces the SAD, a threshold-match flag and, optionally, the block peak. It is the sequential back end of the block-matching datapath: the combinational diff stage feeds it, and a match selector consumes its output.

---
 rtl/sad_accumulator.sv | 114 +++++++++++
 1 files changed

// File: rtl/sad_accumulator.sv
// Sum-of-absolute-differences accumulator: sums N diff beats per block, flags sad <= thresh.
// Optional block-peak tracking is enabled by defining SAD_PEAK_TRACK_EN; otherwise peak_o is tied to 0.
module sad_accumulator #(
    parameter int N = 16,
    parameter int W = 8,
    localparam int SW = W + $clog2(N)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          start_i,
    input  logic [W-1:0]  diff_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [SW-1:0] thresh_i,
    output logic [SW-1:0] sad_o,
    output logic          hit_o,
    output logic [W-1:0]  peak_o,
    output logic          out_valid_o,
    input  logic          out_ready_i
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t        state_q;
    logic [SW-1:0] acc_q, acc_d, thresh_q, sad_q;
    logic [CW-1:0] cnt_q;
    logic          hit_q, in_ready_q, out_valid_q;
    logic          start_acc;

    assign acc_d     = acc_q + SW'(diff_i);
    // A new block can open from IDLE, or straight out of DONE when the result is taken.
    assign start_acc = start_i && ((state_q == IDLE) || (state_q == DONE && out_ready_i));

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            thresh_q    <= '0;
            sad_q       <= '0;
            hit_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q    <= ACCUM;
                        in_ready_q <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (in_valid_i) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST) begin
                            state_q     <= DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            sad_q       <= acc_d;
                            hit_q       <= (acc_d <= thresh_q);
                        end
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        if (start_i) begin
                            state_q    <= ACCUM;
                            in_ready_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (start_acc) begin
                acc_q    <= '0;
                cnt_q    <= '0;
                thresh_q <= thresh_i;
            end
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign sad_o       = sad_q;
    assign hit_o       = hit_q;

`ifdef SAD_PEAK_TRACK_EN
    logic [W-1:0] peak_q;
    logic         beat;

    assign beat = (state_q == ACCUM) && in_valid_i;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            peak_q <= '0;
        end else if (start_acc) begin
            peak_q <= '0;
        end else if (beat && (diff_i > peak_q)) begin
            peak_q <= diff_i;
        end
    end

    assign peak_o = peak_q;
`else
    assign peak_o = '0;
`endif

endmodule
